// File: rtl/dma_periph_rx_fifo_pkg.sv
// Shared constants for the DMA peripheral receive path.
//   DMA_DATA_W     : peripheral word width seen by basic_dma
//   DMA_FIFO_DEPTH : default receive FIFO depth (power of two)
//   DMA_FIFO_AFULL : default almost-full threshold
//   dma_lvl_w()    : width needed to hold a level of 0..depth inclusive
package dma_pkg;

  localparam int DMA_DATA_W     = 32;
  localparam int DMA_FIFO_DEPTH = 16;
  localparam int DMA_FIFO_AFULL = 12;

  // The level counter must represent DEPTH itself, hence the extra bit.
  function automatic int dma_lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dma_periph_rx_fifo_if.sv
// Handshake bundle between the peripheral, the receive FIFO and the DMA.
//   wr_valid/wr_data/wr_ready : peripheral -> FIFO valid/ready write channel
//   dma_rd                    : DMA pop request (peripheral_read)
//   dma_data/dma_data_ready   : FIFO head word towards the DMA
// master modport : the peripheral/DMA side; slave modport : the FIFO.
interface dma_periph_rx_fifo_if
  import dma_pkg::*;
#(
  parameter int DATA_W = DMA_DATA_W
);

  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              dma_rd;
  logic [DATA_W-1:0] dma_data;
  logic              dma_data_ready;

  modport master (
    output wr_valid, wr_data, dma_rd,
    input  wr_ready, dma_data, dma_data_ready
  );

  modport slave (
    input  wr_valid, wr_data, dma_rd,
    output wr_ready, dma_data, dma_data_ready
  );

endinterface

// File: rtl/dma_fifo_ram.sv
// Storage array for the receive FIFO: DEPTH x DATA_W, one synchronous write
// port and one asynchronous read port. Contents are never reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : word at raddr (combinational)
module dma_fifo_ram
  import dma_pkg::*;
#(
  parameter int DATA_W = DMA_DATA_W,
  parameter int DEPTH  = DMA_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dma_periph_rx_fifo.sv
// Peripheral-side ingress FIFO feeding basic_dma. First-word-fall-through:
// the head word is presented on dma_data whenever the FIFO is non-empty and
// is consumed by dma_rd.
//   clk, reset   : clock, synchronous active-high reset
//   bus          : write channel from the peripheral, read channel to the DMA
//   flush        : discard all stored words (beats a same-cycle push/pop)
//   clr_err      : clear sticky overflow/underflow (a same-cycle set wins)
//   level        : words stored, 0..DEPTH
//   almost_full  : level >= AFULL_THRESH
//   overflow     : sticky, wr_valid seen while full
//   underflow    : sticky, dma_rd seen while empty
module dma_periph_rx_fifo
  import dma_pkg::*;
#(
  parameter int DATA_W       = DMA_DATA_W,
  parameter int DEPTH        = DMA_FIFO_DEPTH,
  parameter int AFULL_THRESH = DMA_FIFO_AFULL,
  localparam int LVL_W       = dma_lvl_w(DEPTH),
  localparam int PTR_W       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  dma_periph_rx_fifo_if.slave  bus,
  input  logic                 flush,
  input  logic                 clr_err,
  output logic [LVL_W-1:0]     level,
  output logic                 almost_full,
  output logic                 overflow,
  output logic                 underflow
);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              empty, full, push, pop;
  logic [DATA_W-1:0] head_data;

  // Status is decoded from registered state only.
  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_W'(DEPTH));

  assign bus.wr_ready       = !full && !reset;
  assign bus.dma_data_ready = !empty;
  assign bus.dma_data       = empty ? '0 : head_data;

  assign push = bus.wr_valid && !full && !reset;
  assign pop  = bus.dma_rd && !empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    // Error flags ignore flush; a set in the same cycle as clr_err survives.
    overflow_d  = (overflow_q  && !clr_err) || (bus.wr_valid && full);
    underflow_d = (underflow_q && !clr_err) || (bus.dma_rd   && empty);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // A flushed push must not land in storage.
  dma_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (wr_ptr_q),
    .wdata (bus.wr_data),
    .raddr (rd_ptr_q),
    .rdata (head_data)
  );

  assign level       = level_q;
  assign almost_full = (level_q >= LVL_W'(AFULL_THRESH));
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_dma_periph_rx_fifo.sv
// Bench for dma_periph_rx_fifo: directed scenarios followed by randomized
// traffic. A queue model tracks FIFO contents and sticky flags; every expected
// pop word is pushed to a scoreboard consumed by an independent monitor.
module tb_dma_periph_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       clr_err;
  logic [4:0] level;
  logic       almost_full;
  logic       overflow;
  logic       underflow;

  dma_periph_rx_fifo_if #(.DATA_W(32)) bus ();

  dma_periph_rx_fifo dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .flush       (flush),
    .clr_err     (clr_err),
    .level       (level),
    .almost_full (almost_full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents as a queue plus sticky flags.
  logic [31:0] mq[$];
  logic [31:0] exp_q[$];
  bit          m_ovf = 1'b0;
  bit          m_udf = 1'b0;
  bit          m_rst = 1'b1;
  string       phase = "init";

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %h expected %h", phase, nm, act, exp);
    end
  endtask

  task automatic chk_status();
    int sz;
    sz = mq.size();
    chk("level",          32'(level),              32'(sz));
    chk("almost_full",    32'(almost_full),        32'(sz >= AFULL));
    chk("dma_data_ready", 32'(bus.dma_data_ready), 32'(sz != 0));
    chk("dma_data",       bus.dma_data,            (sz != 0) ? mq[0] : 32'h0);
    chk("wr_ready",       32'(bus.wr_ready),       32'(!m_rst && sz < DEPTH));
    chk("overflow",       32'(overflow),           32'(m_ovf));
    chk("underflow",      32'(underflow),          32'(m_udf));
  endtask

  // One clock of stimulus; the model advances with the edge, then status is checked.
  task automatic step(bit wv, logic [31:0] wd, bit rd,
                      bit fl = 1'b0, bit ce = 1'b0, bit rst = 1'b0);
    bit full, empty;
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.dma_rd   = rd;
    flush        = fl;
    clr_err      = ce;
    reset        = rst;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    if (rd && !empty && !rst) exp_q.push_back(mq[0]);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (ce) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
      if (wv && full)  m_ovf = 1'b1;
      if (rd && empty) m_udf = 1'b1;
      if (fl) mq.delete();
      else begin
        if (rd && !empty) void'(mq.pop_front());
        if (wv && !full)  mq.push_back(wd);
      end
    end
    m_rst = rst;
    #1;
    chk_status();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (mq.size() > 0 && guard < 64) begin
      step(1'b0, 32'h0, 1'b1);
      guard++;
    end
  endtask

  // Monitor: every accepted pop must match the next scoreboard entry.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.dma_rd === 1'b1 && bus.dma_data_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_data: got %h expected no pop", bus.dma_data);
      end else begin
        chk("pop_data", bus.dma_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.dma_rd   = 1'b0;
    flush        = 1'b0;
    clr_err      = 1'b0;
    reset        = 1'b1;

    phase = "reset";
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    phase = "first_push";
    step(1, 32'hA5A5_0001, 0);
    step(0, 0, 1);

    phase = "fill";
    for (int i = 0; i < 16; i++) step(1, 32'(i), 0);
    phase = "overflow";
    step(1, 32'hDEAD_BEEF, 0);
    phase = "drain16";
    for (int i = 0; i < 16; i++) step(0, 0, 1);
    step(0, 0, 0, 0, 1);

    phase = "full_pop_push";
    for (int i = 0; i < 16; i++) step(1, 32'h100 + 32'(i), 0);
    step(1, 32'h200, 1);
    step(1, 32'h200, 0);
    phase = "wrap";
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) step(0, 0, 1);
      else            step(1, $urandom, 0);
    end
    drain();

    phase = "pushpop5";
    for (int i = 0; i < 5; i++) step(1, 32'h300 + 32'(i), 0);
    for (int i = 0; i < 3; i++) step(1, $urandom, 1);
    drain();

    phase = "underflow";
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);

    phase = "flush";
    for (int i = 0; i < 7; i++) step(1, 32'h400 + 32'(i), 0);
    step(1, 32'h4FF, 0, 1);
    phase = "mid_reset";
    for (int i = 0; i < 3; i++) step(1, 32'h500 + 32'(i), 0);
    step(1, 32'h5FF, 0, 0, 0, 1);
    step(0, 0, 0);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 3) != 0, $urandom, ($urandom % 2) == 1,
           ($urandom % 50) == 0, ($urandom % 25) == 0);
    end
    drain();
    step(0, 0, 0);

    phase = "end";
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
